startup_reset_seq: RTL
======================

Name: startup_reset_seq

Overview:
- Parametrised global startup/reset sequencer for the cortex_m0_mcu subsystem; synthesisable successor to the simulation-only global-set-reset/tristate pulse generator.
- Holds a global set/reset (GSR) and global tristate (GTS) after power-on, then releases NUM_CH active-low domain resets in staggered order.
- Waits for PLL lock before starting.
- Re-runs the sequence on a software reset request, a core lockup, or PLL loss, and records the cause.

Parameters:
NUM_CH, 4, number of sequenced reset channels (1..16)
ROC_CYCLES, 16, GSR hold length in FCLK cycles after lock (>=1)
TOC_CYCLES, 4, cycles from GSR release to GTS release (>=0)
STAGE_GAP, 2, cycles between successive channel releases (>=1)
SYNC_STAGES, 2, PLL_LOCK synchroniser depth (>=2)

Ports:
FCLK  in  1  free-running clock
PORESETn  in  1  power-on reset; asynchronous, active-low
PLL_LOCK  in  1  PLL lock, asynchronous to FCLK; synchronised internally
SYSRESETREQ  in  1  core system reset request; FCLK-synchronous level
LOCKUP  in  1  core lockup indication; FCLK-synchronous level
LOCKUP_RST_EN  in  1  enables LOCKUP as a reset source
GSR  out  1  global set/reset; active-high
GTS  out  1  global tristate; active-high
RST_N  out  NUM_CH  domain resets; active-low; bit 0 released first
SEQ_DONE  out  1  high while all resets are released
RST_CAUSE  out  2  last cause: 0 POR, 1 SYSRESETREQ, 2 LOCKUP, 3 PLL loss

Behaviour:
- Reset: one clock (FCLK); reset (PORESETn) is asynchronous and active-low.
- While PORESETn=0, all outputs are driven async:
  - GSR=1, GTS=1, RST_N=0, SEQ_DONE=0, RST_CAUSE=0.
  - State WAIT_LOCK; all counters 0; synchroniser flops 0.
- All outputs are registered. Deassertion of PORESETn is consumed synchronously; no combinational path from any input to any output.
- lock_s: PLL_LOCK after SYNC_STAGES flops.
- State WAIT_LOCK: all resets asserted. On an edge with lock_s=1, go to HOLD with cnt=0.
- State HOLD: GSR=1; cnt increments each edge. On the edge where cnt==ROC_CYCLES-1:
  - go to STAGE;
  - GSR<=0 and RST_N[0]<=1 on that same edge;
  - start the gap counter and the TOC counter.
- GTS: deasserts TOC_CYCLES edges after the GSR-fall edge. If TOC_CYCLES=0, it falls on the same edge as GSR.
- State STAGE: RST_N[k] rises on edge (GSR-fall + k*STAGE_GAP). Released bits stay 1.
- Go to RUN and set SEQ_DONE=1 on the edge after both the last channel and GTS are released.
- State RUN: outputs steady (GSR=0, GTS=0, RST_N all 1, SEQ_DONE=1).
- Restart events (evaluated every edge outside WAIT_LOCK):
  - pll_loss = (lock_s==0);
  - lockup_ev = LOCKUP & LOCKUP_RST_EN;
  - sys_ev = SYSRESETREQ.
- On any restart event, at the next edge:
  - GSR<=1, GTS<=1, RST_N<=0, SEQ_DONE<=0;
  - counters cleared; state WAIT_LOCK;
  - RST_CAUSE<=3/2/1 respectively.
- Simultaneous restart events: priority pll_loss > lockup_ev > sys_ev.
- SYSRESETREQ and LOCKUP held high: the sequence stalls in WAIT_LOCK/HOLD re-entry. Each edge in HOLD/STAGE with the event active restarts, so no release occurs until the request drops.
- pll_loss during HOLD or STAGE: immediate restart, cause 3, partial releases revoked.
- Restart in WAIT_LOCK: sys_ev and lockup_ev are ignored (already in reset); RST_CAUSE is not updated.
- RST_CAUSE is cleared only by PORESETn.
- Counters: width $clog2 of the largest of ROC_CYCLES, TOC_CYCLES and NUM_CH*STAGE_GAP, plus 1. Counters saturate and never wrap.

Test Plan:
- POR, defaults, PLL_LOCK=1 before release; edge 1 = first FCLK rise after PORESETn rises:
  - lock_s=1 at edge 2, HOLD at edge 3;
  - GSR falls at edge 19 and RST_N[0]=1 at edge 19;
  - RST_N[1..3] rise at edges 21, 23, 25; GTS falls at edge 23;
  - SEQ_DONE=1 at edge 26; RST_CAUSE=0.
- PLL_LOCK held 0 for 50 cycles after POR: all outputs held asserted throughout. Sequence timing then matches the POR scenario, offset from the lock_s rise.
- SYSRESETREQ pulsed 1 cycle in RUN:
  - next edge: GSR=1, GTS=1, RST_N=0, SEQ_DONE=0, RST_CAUSE=1;
  - sequence re-runs in 2+16+6+1 cycles;
  - repeat with LOCKUP=1: LOCKUP_RST_EN=0 gives no effect; LOCKUP_RST_EN=1 gives RST_CAUSE=2.
- PLL_LOCK dropped in STAGE after RST_N=4'b0011: 2 cycles later RST_N=0, GSR=1, RST_CAUSE=3. No release until lock returns.
- SYSRESETREQ and LOCKUP (enabled) and PLL loss in the same cycle gives RST_CAUSE=3; SYSRESETREQ with LOCKUP (enabled) gives RST_CAUSE=2.
- PORESETn asserted mid-STAGE: all outputs reset asynchronously within the same cycle and RST_CAUSE=0. Parameter sweep NUM_CH=1, TOC_CYCLES=0: GTS falls with GSR and SEQ_DONE rises one edge later.

Source files
------------

// File: rtl/startup_reset_seq.sv
// -----------------------------------------------------------------------------
// startup_reset_seq
//   Global startup / reset sequencer for the cortex_m0_mcu subsystem.
//   After power-on and PLL lock it holds GSR for ROC_CYCLES, then drops GSR,
//   releases the active-low domain resets one by one (bit 0 first, STAGE_GAP
//   cycles apart) and drops GTS TOC_CYCLES after GSR. A software reset
//   request, an enabled core lockup or loss of PLL lock re-runs the whole
//   sequence and records the cause.
//
// Ports
//   FCLK           in   free-running clock
//   PORESETn       in   power-on reset, asynchronous, active-low
//   PLL_LOCK       in   PLL lock, asynchronous to FCLK
//   SYSRESETREQ    in   core system reset request (FCLK-synchronous level)
//   LOCKUP         in   core lockup indication (FCLK-synchronous level)
//   LOCKUP_RST_EN  in   lets LOCKUP act as a reset source
//   GSR            out  global set/reset, active-high
//   GTS            out  global tristate, active-high
//   RST_N          out  [NUM_CH] domain resets, active-low
//   SEQ_DONE       out  high while every reset is released
//   RST_CAUSE      out  [2] last cause: 0 POR, 1 SYSRESETREQ, 2 LOCKUP, 3 PLL loss
//
// States
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   WAIT_LOCK  | everything asserted, waiting for synchronised PLL lock
//   HOLD       | GSR held for ROC_CYCLES
//   STAGE      | GSR released; channels and GTS being released in turn
//   RUN        | all resets released, SEQ_DONE high
// -----------------------------------------------------------------------------
module startup_reset_seq #(
  parameter int NUM_CH      = 4,
  parameter int ROC_CYCLES  = 16,
  parameter int TOC_CYCLES  = 4,
  parameter int STAGE_GAP   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic              FCLK,
  input  logic              PORESETn,
  input  logic              PLL_LOCK,
  input  logic              SYSRESETREQ,
  input  logic              LOCKUP,
  input  logic              LOCKUP_RST_EN,
  output logic              GSR,
  output logic              GTS,
  output logic [NUM_CH-1:0] RST_N,
  output logic              SEQ_DONE,
  output logic [1:0]        RST_CAUSE
);

  localparam int MAX_A = (ROC_CYCLES > TOC_CYCLES) ? ROC_CYCLES : TOC_CYCLES;
  localparam int MAX_B = NUM_CH * STAGE_GAP;
  localparam int MAX_V = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_V) + 1;

  localparam logic [CW-1:0] ROC_LAST = CW'(ROC_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(STAGE_GAP - 1);
  // Only consulted while GTS is still high, which never happens when TOC is 0.
  localparam logic [CW-1:0] TOC_LAST = CW'((TOC_CYCLES > 0) ? TOC_CYCLES - 1 : 0);

  localparam logic [1:0] CAUSE_POR  = 2'd0;
  localparam logic [1:0] CAUSE_SYS  = 2'd1;
  localparam logic [1:0] CAUSE_LOCK = 2'd2;
  localparam logic [1:0] CAUSE_PLL  = 2'd3;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    STAGE     = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t              state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       gap_q;
  logic [CW-1:0]       toc_q;
  logic                gsr_q;
  logic                gts_q;
  logic [NUM_CH-1:0]   rst_n_q;
  logic                done_q;
  logic [1:0]          cause_q;

  logic                lock_s;
  logic                restart_d;
  logic [1:0]          cause_d;

  // PLL_LOCK synchroniser
  always_ff @(posedge FCLK or negedge PORESETn) begin
    if (!PORESETn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], PLL_LOCK};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Restart sources, highest priority first. WAIT_LOCK already holds every
  // reset, so nothing restarts there and the recorded cause is left alone.
  always_comb begin
    restart_d = 1'b0;
    cause_d   = cause_q;
    if (state_q != WAIT_LOCK) begin
      if (!lock_s) begin
        restart_d = 1'b1;
        cause_d   = CAUSE_PLL;
      end else if (LOCKUP && LOCKUP_RST_EN) begin
        restart_d = 1'b1;
        cause_d   = CAUSE_LOCK;
      end else if (SYSRESETREQ) begin
        restart_d = 1'b1;
        cause_d   = CAUSE_SYS;
      end
    end
  end

  always_ff @(posedge FCLK or negedge PORESETn) begin
    if (!PORESETn) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      gap_q   <= '0;
      toc_q   <= '0;
      gsr_q   <= 1'b1;
      gts_q   <= 1'b1;
      rst_n_q <= '0;
      done_q  <= 1'b0;
      cause_q <= CAUSE_POR;
    end else if (restart_d) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      gap_q   <= '0;
      toc_q   <= '0;
      gsr_q   <= 1'b1;
      gts_q   <= 1'b1;
      rst_n_q <= '0;
      done_q  <= 1'b0;
      cause_q <= cause_d;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (lock_s) begin
            state_q <= HOLD;
            cnt_q   <= '0;
          end
        end

        HOLD: begin
          if (cnt_q == ROC_LAST) begin
            // GSR falls and channel 0 is released on the same edge; both
            // the gap and TOC timers start from here.
            state_q <= STAGE;
            cnt_q   <= '0;
            gap_q   <= '0;
            toc_q   <= '0;
            gsr_q   <= 1'b0;
            gts_q   <= (TOC_CYCLES == 0) ? 1'b0 : 1'b1;
            rst_n_q <= NUM_CH'(1);
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        STAGE: begin
          if ((&rst_n_q) && !gts_q) begin
            state_q <= RUN;
            done_q  <= 1'b1;
          end else begin
            // Released bits are always a contiguous run from bit 0, so the
            // next release is a shift-in of a one.
            if (!(&rst_n_q)) begin
              if (gap_q == GAP_LAST) begin
                rst_n_q <= (rst_n_q << 1) | NUM_CH'(1);
                gap_q   <= '0;
              end else if (gap_q != '1) begin
                gap_q <= gap_q + 1'b1;
              end
            end
            if (gts_q) begin
              if (toc_q == TOC_LAST) begin
                gts_q <= 1'b0;
              end else if (toc_q != '1) begin
                toc_q <= toc_q + 1'b1;
              end
            end
          end
        end

        RUN: begin
          done_q <= 1'b1;
        end

        default: begin
          state_q <= WAIT_LOCK;
        end
      endcase
    end
  end

  assign GSR       = gsr_q;
  assign GTS       = gts_q;
  assign RST_N     = rst_n_q;
  assign SEQ_DONE  = done_q;
  assign RST_CAUSE = cause_q;

endmodule
